// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3.
// Each input bit takes one ADD3 clock and one SHIFT clock; the result is published on DONE entry.
module bin2bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [IN_W-1:0]       bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    bin_sh_q, bin_sh_d;
  logic [BCD_W-1:0]   bcd_sh_q, bcd_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_d;
  logic               busy_d, done_d;

  // Digits of 5..9 are pre-corrected so the following left shift carries into the next digit.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bin_sh_q <= '0;
      bcd_sh_q <= '0;
      cnt_q    <= '0;
      bcd_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_sh_q <= bin_sh_d;
      bcd_sh_q <= bcd_sh_d;
      cnt_q    <= cnt_d;
      bcd_out  <= bcd_out_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_sh_d  = bin_sh_q;
    bcd_sh_d  = bcd_sh_q;
    cnt_d     = cnt_q;
    bcd_out_d = bcd_out;
    busy_d    = busy;
    done_d    = done;
    case (state_q)
      IDLE: begin
        if (init) begin
          bin_sh_d = bin_in;
          bcd_sh_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ADD3;
        end
      end
      ADD3: begin
        bcd_sh_d = add3_digits(bcd_sh_q);
        state_d  = SHIFT;
      end
      SHIFT: begin
        bcd_sh_d = {bcd_sh_q[BCD_W-2:0], bin_sh_q[IN_W-1]};
        bin_sh_d = {bin_sh_q[IN_W-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_out_d = {bcd_sh_q[BCD_W-2:0], bin_sh_q[IN_W-1]};
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          state_d   = ADD3;
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (!init) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
